// File: rtl/pwm_pkg.sv
// pwm_pkg: state encoding, timing defaults and widths shared by the servo PWM generator and capture.
package pwm_pkg;
  typedef enum logic [1:0] {S_WAIT_LOW, S_WAIT_RISE, S_OFFSET, S_STEPS} state_e;
  localparam int TICK_OFFSET = 14400;
  localparam int TICK_STEP = 240;
  localparam int CLK_PER_TICK = 2;
  localparam int OFFSET_CYC_DEF = TICK_OFFSET * CLK_PER_TICK;
  localparam int STEP_CYC_DEF = TICK_STEP * CLK_PER_TICK;
  localparam int MIN_CYC_DEF = 48;
  localparam int MAX_HIGH_CYC_DEF = 192000;
  localparam int LOST_CYC_DEF = 1200000;
  localparam int ANGLE_W = 8;
  localparam int PULSE_W = 18;
endpackage

// File: rtl/input_sync.sv
// input_sync: 2-flop synchronizer plus a registered previous sample for edge detection.
module input_sync (
  input  logic clk,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [1:0] sync_q;
  logic prev_q;
  // Left unreset so s follows the pin during reset and a pulse high at release is seen as high.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], d_i};
    prev_q <= sync_q[1];
  end
  assign s_o = sync_q[1];
  assign rise_o = sync_q[1] & ~prev_q;
  assign fall_o = ~sync_q[1] & prev_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: decodes servo PWM high time into an 8-bit angle incrementally, without a divider.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int OFFSET_CYC   = OFFSET_CYC_DEF,
  parameter int STEP_CYC     = STEP_CYC_DEF,
  parameter int MIN_CYC      = MIN_CYC_DEF,
  parameter int MAX_HIGH_CYC = MAX_HIGH_CYC_DEF,
  parameter int LOST_CYC     = LOST_CYC_DEF
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               pwm_in,
  output logic [ANGLE_W-1:0] angle,
  output logic [PULSE_W-1:0] pulse_cyc,
  output logic               valid,
  output logic               under_range,
  output logic               over_range,
  output logic               signal_lost
);
  localparam int SW = $clog2(STEP_CYC);
  localparam int LW = $clog2(LOST_CYC + 1);
  localparam logic [PULSE_W-1:0] HALF_W = PULSE_W'(OFFSET_CYC - STEP_CYC / 2);
  localparam logic [PULSE_W-1:0] OFF_W = PULSE_W'(OFFSET_CYC);
  localparam logic [PULSE_W-1:0] MIN_W = PULSE_W'(MIN_CYC);
  localparam logic [PULSE_W-1:0] MAX_W = PULSE_W'(MAX_HIGH_CYC);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);
  localparam logic [LW-1:0] LOST_L = LW'(LOST_CYC);
  logic s, rise, fall;
  state_e state_q;
  logic [PULSE_W-1:0] w_q, w_d, pulse_q;
  logic [SW-1:0] step_q;
  logic [ANGLE_W-1:0] acc_q, angle_q;
  logic [LW-1:0] lost_q, lost_d;
  logic ovf_q, valid_q, under_q, over_q, signal_lost_q, signal_lost_d;
  logic step_wrap, stuck, publish, counting;
  input_sync u_sync (
    .clk   (CLK),
    .d_i   (pwm_in),
    .s_o   (s),
    .rise_o(rise),
    .fall_o(fall)
  );
  // Counting starts HALF_W cycles in, so each STEP wrap lands on a rounding boundary.
  always_comb begin
    counting = (state_q == S_OFFSET) || (state_q == S_STEPS);
    w_d = (&w_q) ? w_q : w_q + 1'b1;
    step_wrap = step_q == STEP_LAST;
    stuck = counting && s && (w_d > MAX_W);
    publish = fall && ((state_q == S_STEPS) || ((state_q == S_OFFSET) && (w_q >= MIN_W)));
    lost_d = publish ? '0 : ((lost_q == LOST_L) ? lost_q : lost_q + 1'b1);
    signal_lost_d = !publish && (signal_lost_q || stuck || (lost_d == LOST_L));
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= S_WAIT_LOW;
      w_q <= '0;
      step_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
      lost_q <= '0;
      valid_q <= 1'b0;
      angle_q <= '0;
      pulse_q <= '0;
      under_q <= 1'b0;
      over_q <= 1'b0;
      signal_lost_q <= 1'b0;
    end else begin
      valid_q <= publish;
      lost_q <= lost_d;
      signal_lost_q <= signal_lost_d;
      if (publish) begin
        angle_q <= acc_q;
        pulse_q <= w_q;
        under_q <= w_q < OFF_W;
        over_q <= ovf_q;
      end
      case (state_q)
        S_WAIT_LOW: if (!s) state_q <= S_WAIT_RISE;
        S_WAIT_RISE: if (rise) begin
          w_q <= PULSE_W'(1);
          step_q <= '0;
          acc_q <= '0;
          ovf_q <= 1'b0;
          state_q <= S_OFFSET;
        end
        S_OFFSET: if (fall) state_q <= S_WAIT_RISE;
          else if (stuck) state_q <= S_WAIT_LOW;
          else begin
            w_q <= w_d;
            step_q <= '0;
            if (w_d == HALF_W) state_q <= S_STEPS;
          end
        S_STEPS: if (fall) state_q <= S_WAIT_RISE;
          else if (stuck) state_q <= S_WAIT_LOW;
          else begin
            w_q <= w_d;
            step_q <= step_wrap ? '0 : step_q + 1'b1;
            if (step_wrap) begin
              if (&acc_q) ovf_q <= 1'b1;
              else acc_q <= acc_q + 1'b1;
            end
          end
        default: state_q <= S_WAIT_LOW;
      endcase
    end
  end
  assign angle = angle_q;
  assign pulse_cyc = pulse_q;
  assign valid = valid_q;
  assign under_range = under_q;
  assign over_range = over_q;
  assign signal_lost = signal_lost_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM pulses with a scoreboard of expected decodes, on scaled-down timing.
module tb_pwm_capture;
  localparam int OFF = 40;
  localparam int STEP = 8;
  localparam int MINC = 4;
  localparam int MAXH = 2500;
  localparam int LOST = 5000;
  localparam int GAP = 100;
  typedef struct {
    int angle;
    int pulse;
    bit under;
    bit over;
  } exp_t;
  exp_t sb[$];
  logic CLK = 1'b0;
  logic rst = 1'b1;
  logic pwm_in = 1'b1;
  logic [7:0] angle;
  logic [17:0] pulse_cyc;
  logic valid, under_range, over_range, signal_lost;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int nvalid = 0;
  int snap;
  pwm_capture #(
    .OFFSET_CYC  (OFF),
    .STEP_CYC    (STEP),
    .MIN_CYC     (MINC),
    .MAX_HIGH_CYC(MAXH),
    .LOST_CYC    (LOST)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .angle      (angle),
    .pulse_cyc  (pulse_cyc),
    .valid      (valid),
    .under_range(under_range),
    .over_range (over_range),
    .signal_lost(signal_lost)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  always @(negedge CLK) begin
    if (valid === 1'b1) begin
      exp_t e;
      nvalid++;
      last_valid_cyc = cyc;
      chk("sb_pending", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("angle", 32'(angle), e.angle);
        chk("pulse_cyc", 32'(pulse_cyc), e.pulse);
        chk("under_range", 32'(under_range), 32'(e.under));
        chk("over_range", 32'(over_range), 32'(e.over));
        chk("lost_at_valid", 32'(signal_lost), 0);
      end
    end
  end
  task automatic send(input int w, input bit exp_v);
    exp_t e;
    int a, lat;
    if (exp_v) begin
      a = w - OFF + STEP / 2;
      e.angle = (a < 0) ? 0 : ((a / STEP > 255) ? 255 : a / STEP);
      e.pulse = w;
      e.under = w < OFF;
      e.over = (a >= 0) && (a / STEP > 255);
      sb.push_back(e);
    end
    @(negedge CLK) pwm_in = 1'b1;
    repeat (w) @(negedge CLK);
    pwm_in = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge CLK);
      if (valid === 1'b1) lat = i;
    end
    if (exp_v) chk($sformatf("latency_w%0d", w), 32'((lat >= 3) && (lat <= 4)), 1);
    else chk($sformatf("no_valid_w%0d", w), 32'(lat), 0);
    repeat (GAP) @(negedge CLK);
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (5) @(negedge CLK);
    chk("rst_angle", 32'(angle), 0);
    chk("rst_pulse", 32'(pulse_cyc), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_lost", 32'(signal_lost), 0);
    rst = 1'b0;
    repeat (200) @(negedge CLK);
    pwm_in = 1'b0;
    repeat (GAP) @(negedge CLK);
    chk("partial_ignored", 32'(nvalid), 0);
    send(760, 1);
    send(43, 1);
    send(44, 1);
    send(2080, 1);
    send(2084, 1);
    send(20, 1);
    send(3, 0);
    for (int i = 0; i < LOST + 200 && signal_lost !== 1'b1; i++) @(negedge CLK);
    chk("lost_time", 32'(cyc - last_valid_cyc), LOST);
    send(760, 1);
    chk("lost_cleared", 32'(signal_lost), 0);
    snap = nvalid;
    @(negedge CLK) pwm_in = 1'b1;
    repeat (2700) @(negedge CLK);
    chk("stuck_lost", 32'(signal_lost), 1);
    pwm_in = 1'b0;
    repeat (GAP) @(negedge CLK);
    chk("stuck_no_valid", 32'(nvalid), snap);
    send(760, 1);
    snap = nvalid;
    @(negedge CLK) pwm_in = 1'b1;
    repeat (500) @(negedge CLK);
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    chk("mid_rst_angle", 32'(angle), 0);
    chk("mid_rst_pulse", 32'(pulse_cyc), 0);
    chk("mid_rst_flags", 32'({valid, under_range, over_range, signal_lost}), 0);
    rst = 1'b0;
    repeat (300) @(negedge CLK);
    pwm_in = 1'b0;
    repeat (GAP) @(negedge CLK);
    chk("mid_rst_no_valid", 32'(nvalid), snap);
    send(1224, 1);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
